// File: rtl/restoring_divide_fsmd_pkg.sv
// restoring_divide_fsmd_pkg: FSMD state encoding and default width shared by the divider and multiplier FSMDs
package restoring_divide_fsmd_pkg;
  localparam int DEFAULT_DATA_SIZE = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ITERATE  = 3'd2,
    SIGN_FIX = 3'd3,
    FINISH   = 3'd4
  } state_t;
endpackage

// File: rtl/restoring_divide_fsmd_step.sv
// restoring_div_step: one shift / trial-subtract / restore step of unsigned restoring division
module restoring_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] next_rem,
  output logic [W-1:0] next_quo
);
  logic [W:0] trial;
  // rem < dvs <= 2^(W-1) always holds, so the shifted remainder fits in W bits and trial[W] is the borrow
  always_comb begin
    trial    = {rem, quo[W-1]} - {1'b0, dvs};
    next_rem = trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
    next_quo = {quo[W-2:0], ~trial[W]};
  end
endmodule

// File: rtl/restoring_divide_fsmd.sv
// restoring_divide_fsmd: signed multi-cycle restoring divider, truncating quotient, remainder follows the dividend
module restoring_divide_fsmd
  import restoring_divide_fsmd_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [DATA_SIZE-1:0] dividend_i,
  input  logic [DATA_SIZE-1:0] divisor_i,
  output logic                 data_valid_o,
  output logic [DATA_SIZE-1:0] quotient_o,
  output logic [DATA_SIZE-1:0] remainder_o,
  output logic                 divide_by_zero_o
);
  localparam int CW = $clog2(DATA_SIZE + 1);

  state_t               state, next_state;
  logic [DATA_SIZE-1:0] dvd_r, dvs_r, dvs_mag, quo_r, rem_r, step_quo, step_rem;
  logic [CW-1:0]        cnt_r;
  logic                 neg_q, neg_r, dbz_r;

  restoring_div_step #(.W(DATA_SIZE)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_mag),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else         state <= next_state;

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:     next_state = enable_i ? LOAD : IDLE;
      LOAD:     next_state = (dvs_r == '0) ? FINISH : ITERATE;
      ITERATE:  next_state = (cnt_r == CW'(1)) ? SIGN_FIX : ITERATE;
      SIGN_FIX: next_state = FINISH;
      FINISH:   next_state = enable_i ? FINISH : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // quo_r starts as |dividend| and is shifted out while quotient bits shift in
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      dvd_r   <= '0;
      dvs_r   <= '0;
      dvs_mag <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dvd_r <= enable_i ? dividend_i : dvd_r;
          dvs_r <= enable_i ? divisor_i : dvs_r;
        end
        LOAD: begin
          dvs_mag <= dvs_r[DATA_SIZE-1] ? -dvs_r : dvs_r;
          neg_q   <= dvd_r[DATA_SIZE-1] ^ dvs_r[DATA_SIZE-1];
          neg_r   <= dvd_r[DATA_SIZE-1];
          dbz_r   <= dvs_r == '0;
          cnt_r   <= CW'(DATA_SIZE);
          quo_r   <= (dvs_r == '0) ? '1 : (dvd_r[DATA_SIZE-1] ? -dvd_r : dvd_r);
          rem_r   <= (dvs_r == '0) ? dvd_r : '0;
        end
        ITERATE: begin
          quo_r <= step_quo;
          rem_r <= step_rem;
          cnt_r <= cnt_r - CW'(1);
        end
        SIGN_FIX: begin
          quo_r <= neg_q ? -quo_r : quo_r;
          rem_r <= neg_r ? -rem_r : rem_r;
        end
        default: ;
      endcase
    end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      data_valid_o     <= 1'b0;
      quotient_o       <= '0;
      remainder_o      <= '0;
      divide_by_zero_o <= 1'b0;
    end else begin
      data_valid_o     <= state == FINISH;
      quotient_o       <= (state == FINISH) ? quo_r : '0;
      remainder_o      <= (state == FINISH) ? rem_r : '0;
      divide_by_zero_o <= (state == FINISH) & dbz_r;
    end
endmodule

// File: tb/tb_restoring_divide_fsmd.sv
// tb_restoring_divide_fsmd: randomized scoreboard bench for the signed restoring divider
module tb_restoring_divide_fsmd;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i, enable_i;
  logic [DW-1:0] dividend_i, divisor_i;
  logic          data_valid_o, divide_by_zero_o;
  logic [DW-1:0] quotient_o, remainder_o;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    int            start;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0, n_fail = 0, cyc = 0;
  logic          prev_v = 1'b0;
  logic [2*DW:0] held = '0;

  restoring_divide_fsmd #(.DATA_SIZE(DW)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .data_valid_o     (data_valid_o),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o),
    .divide_by_zero_o (divide_by_zero_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero
  function automatic exp_t model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    exp_t e;
    int ai, bi;
    ai = a;
    bi = b;
    e.dbz = bi == 0;
    if (e.dbz) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = DW'(ai / bi);
      e.r = DW'(ai % bi);
    end
    e.lat   = e.dbz ? 2 : DW + 3;
    e.start = cyc + 1;
    return e;
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (data_valid_o && !prev_v) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient_o), 32'(e.q));
        chk("remainder", 32'(remainder_o), 32'(e.r));
        chk("div_by_zero", 32'(divide_by_zero_o), 32'(e.dbz));
        chk("latency", 32'(cyc - e.start), 32'(e.lat));
      end
      held = {quotient_o, remainder_o, divide_by_zero_o};
    end else if (data_valid_o)
      chk("hold_stable", 32'({quotient_o, remainder_o, divide_by_zero_o}), 32'(held));
    prev_v = data_valid_o;
  end

  task automatic wait_valid();
    int i = 0;
    do begin
      @(negedge clk_i);
      dividend_i = DW'($urandom);
      divisor_i  = DW'($urandom);
      i++;
    end while (!data_valid_o && i < 40);
    if (!data_valid_o) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input int hold, input bit drop_early);
    @(negedge clk_i);
    dividend_i = a;
    divisor_i  = b;
    enable_i   = 1'b1;
    sb.push_back(model(a, b));
    if (drop_early) begin
      repeat (4) @(negedge clk_i);
      enable_i = 1'b0;
      wait_valid();
      @(negedge clk_i);
      chk("pulse_width", 32'(data_valid_o), 32'd0);
    end else begin
      wait_valid();
      repeat (hold) @(negedge clk_i);
      enable_i = 1'b0;
    end
  endtask

  // Async reset, then restart 100/7 with enable already high at release
  task automatic reset_and_rerun();
    #2 reset_i = 1'b1;
    #1 chk("async_reset", 32'({data_valid_o, quotient_o, remainder_o, divide_by_zero_o}), 32'd0);
    sb.delete();
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    enable_i   = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    sb.push_back(model(8'sd100, 8'sd7));
    wait_valid();
    @(negedge clk_i);
    enable_i = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    enable_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", 32'({data_valid_o, quotient_o, remainder_o, divide_by_zero_o}), 32'd0);
    reset_i = 1'b0;
    run_op(8'sd100, 8'sd7, 2, 1'b0);
    run_op(-8'sd100, 8'sd7, 1, 1'b0);
    run_op(8'sd100, -8'sd7, 0, 1'b0);
    run_op(8'h80, 8'hFF, 3, 1'b0);
    run_op(8'h80, 8'sd1, 1, 1'b0);
    run_op(8'sd5, 8'sd0, 2, 1'b0);
    run_op(8'h80, 8'sd0, 0, 1'b0);
    run_op(8'sd0, 8'sd0, 1, 1'b0);
    run_op(8'sd127, 8'h80, 1, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    run_op(-8'sd1, 8'sd127, 1, 1'b0);
    run_op(8'sd100, 8'sd7, 0, 1'b1);
    @(negedge clk_i);
    dividend_i = 8'd50;
    divisor_i  = 8'd3;
    enable_i   = 1'b1;
    sb.push_back(model(8'sd50, 8'sd3));
    repeat (5) @(negedge clk_i);
    reset_and_rerun();
    run_op(8'sd77, -8'sd9, 0, 1'b0);
    @(negedge clk_i);
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    enable_i   = 1'b1;
    sb.push_back(model(8'sd100, 8'sd7));
    wait_valid();
    repeat (2) @(negedge clk_i);
    reset_and_rerun();
    for (int k = 0; k < 150; k++)
      run_op(DW'($urandom), ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom),
             int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    repeat (4) @(negedge clk_i);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compares so far", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/restoring_divide_fsmd.md
RESTORING_DIVIDE_FSMD -- requirements
Module: restoring_divide_fsmd

Interface
REQ-001 Parameter: DATA_SIZE, default 8, operand and result width in bits; minimum value 2.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-high.
REQ-004 enable_i  input  1  start request; held high by the requester until the result is consumed.
REQ-005 dividend_i  input  DATA_SIZE  signed two's-complement dividend.
REQ-006 divisor_i  input  DATA_SIZE  signed two's-complement divisor.
REQ-007 data_valid_o  output  1  quotient_o, remainder_o and divide_by_zero_o are valid.
REQ-008 quotient_o  output  DATA_SIZE  signed quotient, truncated toward zero.
REQ-009 remainder_o  output  DATA_SIZE  signed remainder, same sign as the dividend or zero.
REQ-010 divide_by_zero_o  output  1  the divisor was zero for this result.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, ITERATE, SIGN_FIX and FINISH; all outputs SHALL be registered.
REQ-012 IDLE: outputs SHALL be 0; when enable_i=1, dividend_i and divisor_i SHALL be captured on that edge and the next state SHALL be LOAD.
REQ-013 Operand inputs SHALL be ignored outside the IDLE capture edge.
REQ-014 LOAD SHALL store |dividend| and |divisor| as DATA_SIZE-bit unsigned values, record both sign bits, clear the partial remainder and set the iteration counter to DATA_SIZE.
REQ-015 LOAD with divisor==0 SHALL go directly to FINISH with the following results: quotient all ones, remainder equal to the dividend, and divide_by_zero_o=1.
REQ-016 ITERATE SHALL perform one restoring step per cycle.
  - Shift {partial remainder, quotient} left by one bit.
  - Trial-subtract the divisor using DATA_SIZE+1-bit arithmetic.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter.
REQ-017 ITERATE SHALL exit to SIGN_FIX after exactly DATA_SIZE steps.
REQ-018 SIGN_FIX SHALL apply the signs and then go to FINISH.
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
REQ-019 Magnitude -2^(DATA_SIZE-1) SHALL be handled as the unsigned value 2^(DATA_SIZE-1).
  - The case -2^(DATA_SIZE-1) / -1 SHALL wrap to quotient -2^(DATA_SIZE-1) with remainder 0.
  - No flag is raised for this case.
REQ-020 FINISH SHALL hold data_valid_o=1 and the results stable while enable_i=1, and SHALL return to IDLE when enable_i=0.
REQ-021 Latency: with enable_i sampled high at edge N, data_valid_o SHALL be high after edge N+DATA_SIZE+3 (N+11 for DATA_SIZE=8), or after edge N+2 for a zero divisor.
REQ-022 Dropping enable_i before FINISH SHALL NOT abort the operation; data_valid_o SHALL then be high for exactly one cycle.
REQ-023 A new operation SHALL start only after at least one IDLE cycle.
REQ-024 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-025 reset_i=1 SHALL immediately force state IDLE, counter 0, all datapath registers 0 and all outputs 0, regardless of the current state.
REQ-026 After reset_i is deasserted, the block SHALL wait in IDLE for enable_i; an enable_i already high SHALL be captured on the first clock edge after deassertion.

Structure
REQ-027 A shared package SHALL hold the state encoding constants and the default DATA_SIZE; the same package is used by the multiplier FSMD.
REQ-028 A single combinational sub-module, restoring_div_step, SHALL implement one shift/trial-subtract/restore step; ITERATE SHALL instantiate it once.

Verification
REQ-029 100 / 7 -> quotient 14 (0x0E), remainder 2, divide_by_zero_o 0, valid at edge N+11.
REQ-030 -100 / 7 -> quotient 0xF2 (-14), remainder 0xFE (-2); 100 / -7 -> quotient 0xF2, remainder 0x02.
REQ-031 -128 / -1 -> quotient 0x80, remainder 0x00; -128 / 1 -> quotient 0x80, remainder 0x00.
REQ-032 5 / 0 -> quotient 0xFF, remainder 0x05, divide_by_zero_o 1, valid at edge N+2.
REQ-033 Operands changed during ITERATE -> result unchanged; enable_i dropped in ITERATE -> one-cycle valid pulse, then IDLE.
REQ-034 reset_i pulsed mid-ITERATE -> outputs 0 immediately; a following 100 / 7 operation -> correct result (quotient 14, remainder 2).
